multi_core_best_nonce_tracker: RTL and testbench
================================================

# multi_core_best_nonce_tracker

Parametrised best-result tracker for the multi-core xkcd Skein processor. Each cycle of the hashing program ends with every core presenting a bit-distance score. This block scans those scores one core per cycle and keeps the lowest score seen so far, together with its reconstructed nonce and core index. It sits between the core array and the serial readout path, and supports a hold handshake so the serial side can read a stable result.

## Interface
Parameters:
- CORE_COUNT, 4, number of cores scanned; must be ≥1.
- SCORE_WIDTH, 11, score width; unsigned bit-distance in the range 0..1024.
- NONCE_WIDTH, 128, nonce width.
- CORE_IDX_W, max(1, clog2(CORE_COUNT)), width of the core index (derived).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- save_i  in  1  one-cycle pulse; score_i and nonce_i are valid and are captured on this edge.
- score_i  in  CORE_COUNT*SCORE_WIDTH  core k score at bits [k*SCORE_WIDTH +: SCORE_WIDTH].
- nonce_i  in  NONCE_WIDTH  base nonce; core k hashed nonce_i + k.
- reset_best_i  in  1  pulse; clears the best result and the overrun flag.
- hold_i  in  1  level; stalls scanning so the best outputs stay stable.
- busy_o  out  1  high while a scan is in progress.
- done_o  out  1  one-cycle pulse; the scan has completed.
- improved_o  out  1  one-cycle pulse, coincident with done_o; the finished scan updated the best.
- overrun_o  out  1  sticky; a save_i arrived while busy_o was high.
- best_valid_o  out  1  at least one update has occurred since reset or clear.
- best_score_o  out  SCORE_WIDTH  lowest score seen.
- best_nonce_o  out  NONCE_WIDTH  nonce that produced best_score_o.
- best_core_o  out  CORE_IDX_W  index of the core that produced it.

## Operation
- States: IDLE and SCAN.
- IDLE, save_i=1:
  - Latch all scores into shadow registers and nonce_i into base_q.
  - Set idx=0, clear the improved flag, go to SCAN.
- SCAN, hold_i=0, each cycle:
  - If shadow[idx] < best_score, then best_score ← shadow[idx], best_nonce ← base_q + idx, best_core ← idx, best_valid ← 1, improved flag ← 1.
  - If idx == CORE_COUNT-1, go to IDLE and pulse done_o, with improved_o = improved flag. Otherwise idx ← idx+1.
- SCAN, hold_i=1: idx does not advance, no compare is made, and best registers are frozen. hold_i has no effect in IDLE.
- Comparison is strict and unsigned. On a tie the earlier result is kept, so the lowest core index wins within a scan and the earlier scan wins across scans.
- Nonce arithmetic: base_q + idx is computed modulo 2^NONCE_WIDTH, with idx zero-extended. A base of all-ones plus 1 wraps to 0.
- The cleared best_score is all-ones. A score of all-ones therefore never updates the best, and best_valid_o stays 0.
- save_i while in SCAN (including the stalled case): the save is ignored, overrun_o ← 1, and the current scan continues unaffected.
- reset_best_i: best_score ← all-ones, best_nonce ← 0, best_core ← 0, best_valid ← 0, overrun ← 0.
  - If asserted in SCAN, the scan aborts to IDLE with no done_o.
  - If asserted in IDLE together with save_i, the clear and the capture both occur on that edge, and the scan then runs against the cleared best.
- rst_i has the same effect as reset_best_i and also forces IDLE. It overrides everything else.

## Timing
- Reset values: busy_o=0, done_o=0, improved_o=0, overrun_o=0, best_valid_o=0, best_score_o=all-ones, best_nonce_o=0, best_core_o=0.
- All outputs are registered; there are no combinational input-to-output paths.
- Let save_i be sampled at edge t:
  - busy_o is high for cycles t+1 .. t+CORE_COUNT, plus one extra cycle for each cycle hold_i was high during SCAN.
  - done_o and improved_o are high in the first cycle after the final compare.
  - The best outputs are final in that same cycle.
  - Unstalled latency from save to done is CORE_COUNT+1 cycles.
- A save_i in the done_o cycle is accepted, because busy_o is already low. Back-to-back scans are therefore sustainable every CORE_COUNT+1 cycles.
- Best outputs change only on the edge where a compare succeeds, or on a clear/reset edge.
- The serial-side handshake:
  - Assert hold_i.
  - Wait one cycle; best_* are then stable until hold_i drops or reset_best_i/rst_i is asserted.
  - Read the result, then deassert hold_i.

## Test plan
- Basic scan: CORE_COUNT=4, scores {k0=500, k1=300, k2=300, k3=700}, nonce_i=0x10.
  - Expect done_o at t+5, best_score=300, best_core=1, best_nonce=0x11, improved_o=1.
- No improvement: repeat the basic scan with all scores = 400.
  - Expect done_o with improved_o=0, best unchanged at 300/core 1.
- Wrap-around and invalid score:
  - First, after a reset, save scores {all-ones, all-ones, all-ones, all-ones}; expect best_valid_o to stay 0.
  - Then save with nonce_i=all-ones and k1=5 as the only low score; expect best_nonce=0 (wrapped) and best_valid_o=1.
- Overrun and hold:
  - Pulse save_i at t+2 of a scan; expect overrun_o=1 and the scan result unaffected.
  - Hold hold_i high for 3 cycles mid-scan; expect done_o delayed by 3 cycles and best_* constant during the hold.
- Clear edge cases:
  - Assert reset_best_i mid-scan; expect busy_o=0 next cycle, no done_o, all best outputs back at reset values.
  - Assert reset_best_i and save_i together in IDLE; expect a full scan against the cleared best, with overrun_o=0.
- Parametric corners:
  - Rerun the basic scan with CORE_COUNT=1; expect latency 2 and CORE_IDX_W=1.
  - Rerun with CORE_COUNT=8 and SCORE_WIDTH=11, with the lowest score on core 7; expect best_core=7.

Source files
------------

// File: rtl/multi_core_best_nonce_tracker_if.sv
// Bundle of the core-array capture inputs and the registered best-result outputs.
// The core array / serial side drives through master; the tracker uses slave.
interface multi_core_best_nonce_tracker_if #(
   parameter int CORE_COUNT  = 4,
   parameter int SCORE_WIDTH = 11,
   parameter int NONCE_WIDTH = 128,
   parameter int CORE_IDX_W  = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
);
   logic                              save_i;
   logic [CORE_COUNT*SCORE_WIDTH-1:0] score_i;
   logic [NONCE_WIDTH-1:0]            nonce_i;
   logic                              reset_best_i;
   logic                              hold_i;
   logic                              busy_o;
   logic                              done_o;
   logic                              improved_o;
   logic                              overrun_o;
   logic                              best_valid_o;
   logic [SCORE_WIDTH-1:0]            best_score_o;
   logic [NONCE_WIDTH-1:0]            best_nonce_o;
   logic [CORE_IDX_W-1:0]             best_core_o;

   modport master (
      output save_i, score_i, nonce_i, reset_best_i, hold_i,
      input  busy_o, done_o, improved_o, overrun_o,
             best_valid_o, best_score_o, best_nonce_o, best_core_o
   );

   modport slave (
      input  save_i, score_i, nonce_i, reset_best_i, hold_i,
      output busy_o, done_o, improved_o, overrun_o,
             best_valid_o, best_score_o, best_nonce_o, best_core_o
   );
endinterface

// File: rtl/multi_core_best_nonce_tracker.sv
// Scans per-core bit-distance scores one core per cycle and keeps the lowest
// score seen, with its reconstructed nonce and core index.
module multi_core_best_nonce_tracker #(
   parameter int CORE_COUNT  = 4,
   parameter int SCORE_WIDTH = 11,
   parameter int NONCE_WIDTH = 128,
   parameter int CORE_IDX_W  = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1
) (
   input logic                          clk_i,
   input logic                          rst_i,
   multi_core_best_nonce_tracker_if.slave bus
);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SCAN = 1'b1;

   logic [0:0]             state_q, state_d;
   logic [CORE_IDX_W-1:0]  idx_q, idx_d;
   logic [SCORE_WIDTH-1:0] shadow_q [CORE_COUNT];
   logic [SCORE_WIDTH-1:0] shadow_d [CORE_COUNT];
   logic [NONCE_WIDTH-1:0] base_q, base_d;
   logic                   improvedFlag_q, improvedFlag_d;
   logic                   done_q, done_d;
   logic                   improvedOut_q, improvedOut_d;
   logic                   overrun_q, overrun_d;
   logic                   bestValid_q, bestValid_d;
   logic [SCORE_WIDTH-1:0] bestScore_q, bestScore_d;
   logic [NONCE_WIDTH-1:0] bestNonce_q, bestNonce_d;
   logic [CORE_IDX_W-1:0]  bestCore_q, bestCore_d;

   always_comb begin
      state_d        = state_q;
      idx_d          = idx_q;
      shadow_d       = shadow_q;
      base_d         = base_q;
      improvedFlag_d = improvedFlag_q;
      done_d         = 1'b0;
      improvedOut_d  = 1'b0;
      overrun_d      = overrun_q;
      bestValid_d    = bestValid_q;
      bestScore_d    = bestScore_q;
      bestNonce_d    = bestNonce_q;
      bestCore_d     = bestCore_q;

      case (state_q)
         IDLE: begin
            if (bus.save_i) begin
               for (int k = 0; k < CORE_COUNT; k++) begin
                  shadow_d[k] = bus.score_i[k*SCORE_WIDTH +: SCORE_WIDTH];
               end
               base_d         = bus.nonce_i;
               idx_d          = '0;
               improvedFlag_d = 1'b0;
               state_d        = SCAN;
            end
         end
         default: begin
            if (bus.save_i) begin
               overrun_d = 1'b1;
            end
            // A stalled scan makes no compare, so the best registers stay frozen for readout.
            if (!bus.hold_i) begin
               if (shadow_q[idx_q] < bestScore_q) begin
                  bestScore_d    = shadow_q[idx_q];
                  bestNonce_d    = base_q + NONCE_WIDTH'(idx_q);
                  bestCore_d     = idx_q;
                  bestValid_d    = 1'b1;
                  improvedFlag_d = 1'b1;
               end
               if (idx_q == CORE_IDX_W'(CORE_COUNT - 1)) begin
                  state_d       = IDLE;
                  done_d        = 1'b1;
                  improvedOut_d = improvedFlag_d;
               end else begin
                  idx_d = idx_q + CORE_IDX_W'(1);
               end
            end
         end
      endcase

      // Clear wins over any compare; a capture on the same IDLE edge still proceeds.
      if (bus.reset_best_i) begin
         bestScore_d   = '1;
         bestNonce_d   = '0;
         bestCore_d    = '0;
         bestValid_d   = 1'b0;
         overrun_d     = 1'b0;
         if (state_q == SCAN) begin
            state_d       = IDLE;
            done_d        = 1'b0;
            improvedOut_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= IDLE;
         idx_q          <= '0;
         shadow_q       <= '{default: '0};
         base_q         <= '0;
         improvedFlag_q <= 1'b0;
         done_q         <= 1'b0;
         improvedOut_q  <= 1'b0;
         overrun_q      <= 1'b0;
         bestValid_q    <= 1'b0;
         bestScore_q    <= '1;
         bestNonce_q    <= '0;
         bestCore_q     <= '0;
      end else begin
         state_q        <= state_d;
         idx_q          <= idx_d;
         shadow_q       <= shadow_d;
         base_q         <= base_d;
         improvedFlag_q <= improvedFlag_d;
         done_q         <= done_d;
         improvedOut_q  <= improvedOut_d;
         overrun_q      <= overrun_d;
         bestValid_q    <= bestValid_d;
         bestScore_q    <= bestScore_d;
         bestNonce_q    <= bestNonce_d;
         bestCore_q     <= bestCore_d;
      end
   end

   assign bus.busy_o       = (state_q == SCAN);
   assign bus.done_o       = done_q;
   assign bus.improved_o   = improvedOut_q;
   assign bus.overrun_o    = overrun_q;
   assign bus.best_valid_o = bestValid_q;
   assign bus.best_score_o = bestScore_q;
   assign bus.best_nonce_o = bestNonce_q;
   assign bus.best_core_o  = bestCore_q;
endmodule

// File: tb/tb_multi_core_best_nonce_tracker.sv
// Directed bench for the best-nonce tracker: a 4-core instance carries the main
// sequence, with 1-core and 8-core instances covering the parameter corners.
module tb_multi_core_best_nonce_tracker;
   localparam int SW = 11;
   localparam int NW = 128;

   logic clk_i = 1'b0;
   logic rst_i;
   int   checkCount = 0;
   int   errorCount = 0;
   int   cycles;
   int   doneSeen;

   always #5 clk_i = ~clk_i;

   multi_core_best_nonce_tracker_if #(.CORE_COUNT(4), .SCORE_WIDTH(SW), .NONCE_WIDTH(NW)) bus4 ();
   multi_core_best_nonce_tracker_if #(.CORE_COUNT(1), .SCORE_WIDTH(SW), .NONCE_WIDTH(NW)) bus1 ();
   multi_core_best_nonce_tracker_if #(.CORE_COUNT(8), .SCORE_WIDTH(SW), .NONCE_WIDTH(NW)) bus8 ();

   multi_core_best_nonce_tracker #(.CORE_COUNT(4), .SCORE_WIDTH(SW), .NONCE_WIDTH(NW)) dut4 (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus4));
   multi_core_best_nonce_tracker #(.CORE_COUNT(1), .SCORE_WIDTH(SW), .NONCE_WIDTH(NW)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus1));
   multi_core_best_nonce_tracker #(.CORE_COUNT(8), .SCORE_WIDTH(SW), .NONCE_WIDTH(NW)) dut8 (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus8));

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checkCount++;
      assert (observed === expected) else begin
         errorCount++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drives the pulse/level controls of the 4-core instance for one edge, then drops the pulses.
   task automatic applyStimulus(input logic save, input logic resetBest, input logic hold);
      bus4.save_i       = save;
      bus4.reset_best_i = resetBest;
      bus4.hold_i       = hold;
      tick();
      bus4.save_i       = 1'b0;
      bus4.reset_best_i = 1'b0;
   endtask

   task automatic setScores4(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                             input logic [SW-1:0] s2, input logic [SW-1:0] s3);
      bus4.score_i = {s3, s2, s1, s0};
   endtask

   function automatic logic doneOf(input int which);
      case (which)
         1:       return bus1.done_o;
         8:       return bus8.done_o;
         default: return bus4.done_o;
      endcase
   endfunction

   task automatic waitDone(input int which, input int budget, output int count);
      count = 0;
      while (!doneOf(which) && count < budget) begin
         tick();
         count++;
      end
   endtask

   initial begin
      rst_i = 1'b1;
      bus4.save_i = 1'b0; bus4.reset_best_i = 1'b0; bus4.hold_i = 1'b0;
      bus4.score_i = '0; bus4.nonce_i = '0;
      bus1.save_i = 1'b0; bus1.reset_best_i = 1'b0; bus1.hold_i = 1'b0;
      bus1.score_i = '0; bus1.nonce_i = '0;
      bus8.save_i = 1'b0; bus8.reset_best_i = 1'b0; bus8.hold_i = 1'b0;
      bus8.score_i = '0; bus8.nonce_i = '0;
      tick();
      tick();

      $display("[TB] reset state");
      checkOutput("rst_busy", bus4.busy_o, 0);
      checkOutput("rst_done", bus4.done_o, 0);
      checkOutput("rst_improved", bus4.improved_o, 0);
      checkOutput("rst_overrun", bus4.overrun_o, 0);
      checkOutput("rst_valid", bus4.best_valid_o, 0);
      checkOutput("rst_score", bus4.best_score_o, 128'h7ff);
      checkOutput("rst_nonce", bus4.best_nonce_o, 0);
      checkOutput("rst_core", bus4.best_core_o, 0);
      rst_i = 1'b0;
      tick();

      $display("[TB] basic scan");
      setScores4(11'd500, 11'd300, 11'd300, 11'd700);
      bus4.nonce_i = 128'h10;
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("basic_busy", bus4.busy_o, 1);
      waitDone(4, 20, cycles);
      checkOutput("basic_latency", cycles, 4);
      checkOutput("basic_done", bus4.done_o, 1);
      checkOutput("basic_busy_low", bus4.busy_o, 0);
      checkOutput("basic_improved", bus4.improved_o, 1);
      checkOutput("basic_score", bus4.best_score_o, 300);
      checkOutput("basic_core", bus4.best_core_o, 1);
      checkOutput("basic_nonce", bus4.best_nonce_o, 128'h11);
      checkOutput("basic_valid", bus4.best_valid_o, 1);
      tick();
      checkOutput("basic_done_pulse", bus4.done_o, 0);

      $display("[TB] no improvement");
      setScores4(11'd400, 11'd400, 11'd400, 11'd400);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitDone(4, 20, cycles);
      checkOutput("noimp_done", bus4.done_o, 1);
      checkOutput("noimp_improved", bus4.improved_o, 0);
      checkOutput("noimp_score", bus4.best_score_o, 300);
      checkOutput("noimp_core", bus4.best_core_o, 1);
      checkOutput("noimp_nonce", bus4.best_nonce_o, 128'h11);

      $display("[TB] all-ones scores then nonce wrap");
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      setScores4(11'h7ff, 11'h7ff, 11'h7ff, 11'h7ff);
      bus4.nonce_i = '0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitDone(4, 20, cycles);
      checkOutput("ones_done", bus4.done_o, 1);
      checkOutput("ones_valid", bus4.best_valid_o, 0);
      checkOutput("ones_improved", bus4.improved_o, 0);
      checkOutput("ones_score", bus4.best_score_o, 128'h7ff);
      setScores4(11'h7ff, 11'd5, 11'h7ff, 11'h7ff);
      bus4.nonce_i = '1;
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitDone(4, 20, cycles);
      checkOutput("wrap_nonce", bus4.best_nonce_o, 0);
      checkOutput("wrap_score", bus4.best_score_o, 5);
      checkOutput("wrap_core", bus4.best_core_o, 1);
      checkOutput("wrap_valid", bus4.best_valid_o, 1);

      $display("[TB] overrun");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("clr_score", bus4.best_score_o, 128'h7ff);
      setScores4(11'd100, 11'd50, 11'd60, 11'd40);
      bus4.nonce_i = 128'h200;
      applyStimulus(1'b1, 1'b0, 1'b0);
      setScores4(11'd1, 11'd1, 11'd1, 11'd1);
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("ovr_flag", bus4.overrun_o, 1);
      waitDone(4, 20, cycles);
      checkOutput("ovr_latency", cycles, 3);
      checkOutput("ovr_score", bus4.best_score_o, 40);
      checkOutput("ovr_core", bus4.best_core_o, 3);
      checkOutput("ovr_nonce", bus4.best_nonce_o, 128'h203);
      tick();
      checkOutput("ovr_no_rescan", bus4.busy_o, 0);
      checkOutput("ovr_sticky", bus4.overrun_o, 1);

      $display("[TB] hold");
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("hold_ovr_clr", bus4.overrun_o, 0);
      setScores4(11'd20, 11'd30, 11'd10, 11'd40);
      bus4.nonce_i = 128'h300;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int h = 0; h < 3; h++) begin
         applyStimulus(1'b0, 1'b0, 1'b1);
         checkOutput("hold_score", bus4.best_score_o, 20);
         checkOutput("hold_core", bus4.best_core_o, 0);
         checkOutput("hold_busy", bus4.busy_o, 1);
      end
      bus4.hold_i = 1'b0;
      waitDone(4, 20, cycles);
      checkOutput("hold_latency", cycles, 3);
      checkOutput("hold_done", bus4.done_o, 1);
      checkOutput("hold_score_final", bus4.best_score_o, 10);
      checkOutput("hold_core_final", bus4.best_core_o, 2);
      checkOutput("hold_nonce_final", bus4.best_nonce_o, 128'h302);

      $display("[TB] clear mid-scan");
      setScores4(11'd1, 11'd2, 11'd3, 11'd4);
      bus4.nonce_i = 128'h400;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("abort_pre_score", bus4.best_score_o, 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("abort_busy", bus4.busy_o, 0);
      checkOutput("abort_score", bus4.best_score_o, 128'h7ff);
      checkOutput("abort_nonce", bus4.best_nonce_o, 0);
      checkOutput("abort_core", bus4.best_core_o, 0);
      checkOutput("abort_valid", bus4.best_valid_o, 0);
      doneSeen = 0;
      for (int w = 0; w < 6; w++) begin
         if (bus4.done_o) doneSeen++;
         tick();
      end
      checkOutput("abort_no_done", doneSeen, 0);

      $display("[TB] clear with save");
      setScores4(11'd50, 11'd50, 11'd50, 11'd50);
      bus4.nonce_i = '0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitDone(4, 20, cycles);
      checkOutput("pre_ovr", bus4.overrun_o, 1);
      checkOutput("pre_score", bus4.best_score_o, 50);
      setScores4(11'd600, 11'd700, 11'd800, 11'd900);
      bus4.nonce_i = 128'h500;
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("cs_busy", bus4.busy_o, 1);
      checkOutput("cs_ovr", bus4.overrun_o, 0);
      checkOutput("cs_valid_clr", bus4.best_valid_o, 0);
      waitDone(4, 20, cycles);
      checkOutput("cs_latency", cycles, 4);
      checkOutput("cs_improved", bus4.improved_o, 1);
      checkOutput("cs_score", bus4.best_score_o, 600);
      checkOutput("cs_core", bus4.best_core_o, 0);
      checkOutput("cs_nonce", bus4.best_nonce_o, 128'h500);
      checkOutput("cs_ovr_final", bus4.overrun_o, 0);

      $display("[TB] single core");
      bus1.score_i = 11'd300;
      bus1.nonce_i = 128'h10;
      bus1.save_i = 1'b1;
      tick();
      bus1.save_i = 1'b0;
      checkOutput("c1_busy", bus1.busy_o, 1);
      waitDone(1, 20, cycles);
      checkOutput("c1_latency", cycles, 1);
      checkOutput("c1_improved", bus1.improved_o, 1);
      checkOutput("c1_score", bus1.best_score_o, 300);
      checkOutput("c1_core", bus1.best_core_o, 0);
      checkOutput("c1_nonce", bus1.best_nonce_o, 128'h10);

      $display("[TB] eight cores");
      bus8.score_i = {11'd3, 11'd9, 11'd8, 11'd7, 11'd6, 11'd5, 11'd4, 11'd10};
      bus8.nonce_i = 128'h1000;
      bus8.save_i = 1'b1;
      tick();
      bus8.save_i = 1'b0;
      waitDone(8, 40, cycles);
      checkOutput("c8_latency", cycles, 8);
      checkOutput("c8_done", bus8.done_o, 1);
      checkOutput("c8_score", bus8.best_score_o, 3);
      checkOutput("c8_core", bus8.best_core_o, 7);
      checkOutput("c8_nonce", bus8.best_nonce_o, 128'h1007);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end
endmodule
